// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the two-port AXI4 read arbiter.
// Holds the sequencer state encoding and the fixed AR-channel field values.
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  // Beat size encoding: log2 of the bus width in bytes.
  function automatic logic [2:0] axi_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_rd_arb_grant.sv
// Winner selection for the two read requesters.
// AXI_RD_ARB_RR_EN selects round-robin with a 1-bit pointer; otherwise port 1 has fixed priority.
module axi_rd_arb_grant (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req0_valid,
  input  logic i_req1_valid,
  input  logic i_grant_en,
  output logic o_any_req,
  output logic o_winner
);

  assign o_any_req = i_req0_valid | i_req1_valid;

`ifdef AXI_RD_ARB_RR_EN
  logic r_ptr;

  // On a tie the pointer's port wins; otherwise the sole requester wins.
  always_comb begin
    o_winner = i_req1_valid;
    if (i_req0_valid && i_req1_valid) begin
      o_winner = r_ptr;
    end
  end

  // After every grant the pointer favours the port that just lost out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_grant_en) begin
      r_ptr <= ~o_winner;
    end
  end
`else
  logic w_unused;

  assign o_winner = i_req1_valid;
  assign w_unused = clk ^ rst_n ^ i_grant_en;
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-requester burst read arbiter/sequencer driving one AXI4 AR/R channel pair.
// Define AXI_RD_ARB_RR_EN for round-robin arbitration (default: port 1 fixed priority).
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int C_M_AXI_BURST_LEN   = 16,
  parameter int C_M_AXI_ADDR_WIDTH  = 32,
  parameter int C_M_AXI_DATA_WIDTH  = 32,
  parameter int C_M_AXI_ID_WIDTH    = 1
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_aresetn,

  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] req0_addr,
  input  logic [7:0]                    req0_len,
  output logic                          rsp0_valid,
  input  logic                          rsp0_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rsp0_data,
  output logic [1:0]                    rsp0_resp,
  output logic                          rsp0_last,

  input  logic                          req1_valid,
  output logic                          req1_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] req1_addr,
  input  logic [7:0]                    req1_len,
  output logic                          rsp1_valid,
  input  logic                          rsp1_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rsp1_data,
  output logic [1:0]                    rsp1_resp,
  output logic                          rsp1_last,

  output logic                          proto_err,

  output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arlock,
  output logic [3:0]                    m_axi_arcache,
  output logic [2:0]                    m_axi_arprot,
  output logic [3:0]                    m_axi_arqos,
  output logic [0:0]                    m_axi_aruser,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,

  input  logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_rid,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam logic [7:0] MAX_LEN = 8'(C_M_AXI_BURST_LEN - 1);

  arb_state_e                    r_state;
  logic                          r_grant;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                    r_len;
  logic [7:0]                    r_cnt;
  logic                          r_proto_err;

  logic                          w_any_req;
  logic                          w_winner;
  logic                          w_accept;
  logic [7:0]                    w_sel_len;
  logic [7:0]                    w_sat_len;
  logic                          w_in_data;
  logic                          w_rsp_ready;
  logic                          w_beat;
  logic                          w_last;
  logic                          w_unused;

  assign w_accept = (r_state == ST_IDLE) && w_any_req;

  axi_rd_arb_grant u_grant (
    .clk          (m_axi_aclk),
    .rst_n        (m_axi_aresetn),
    .i_req0_valid (req0_valid),
    .i_req1_valid (req1_valid),
    .i_grant_en   (w_accept),
    .o_any_req    (w_any_req),
    .o_winner     (w_winner)
  );

  assign req0_ready = w_accept && !w_winner;
  assign req1_ready = w_accept &&  w_winner;

  assign w_sel_len = w_winner ? req1_len : req0_len;
  assign w_sat_len = (w_sel_len > MAX_LEN) ? MAX_LEN : w_sel_len;

  // The counter, not the slave's rlast, decides where the burst ends.
  assign w_in_data   = (r_state == ST_DATA);
  assign w_rsp_ready = r_grant ? rsp1_ready : rsp0_ready;
  assign w_last      = (r_cnt == r_len);
  assign w_beat      = w_in_data && m_axi_rvalid && w_rsp_ready;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_winner;
            r_addr  <= w_winner ? req1_addr : req0_addr;
            r_len   <= w_sat_len;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_axi_arready) begin
            r_cnt   <= '0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_beat) begin
            r_cnt <= r_cnt + 8'd1;
            if (w_last) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_proto_err <= 1'b0;
    end else if (w_beat && (m_axi_rlast != w_last)) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;

  always_comb begin
    m_axi_arid    = '0;
    m_axi_arid[0] = r_grant;
  end

  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = r_len;
  assign m_axi_arsize  = axi_size(C_M_AXI_DATA_WIDTH);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_DEFAULT;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;
  assign m_axi_aruser  = 1'b0;
  assign m_axi_arvalid = (r_state == ST_ADDR);

  assign m_axi_rready = w_in_data && w_rsp_ready;

  assign rsp0_valid = w_in_data && !r_grant && m_axi_rvalid;
  assign rsp1_valid = w_in_data &&  r_grant && m_axi_rvalid;
  assign rsp0_last  = w_in_data && !r_grant && w_last;
  assign rsp1_last  = w_in_data &&  r_grant && w_last;
  assign rsp0_data  = m_axi_rdata;
  assign rsp1_data  = m_axi_rdata;
  assign rsp0_resp  = m_axi_rresp;
  assign rsp1_resp  = m_axi_rresp;

  assign w_unused = ^m_axi_rid;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed, table-driven bench for axi_rd_arbiter; expected tie winners follow AXI_RD_ARB_RR_EN.
module tb_axi_rd_arbiter;

  logic        clk;
  logic        rstN;
  logic        req0Valid, req0Ready, req1Valid, req1Ready;
  logic [31:0] req0Addr, req1Addr;
  logic [7:0]  req0Len, req1Len;
  logic        rsp0Valid, rsp0Ready, rsp0Last, rsp1Valid, rsp1Ready, rsp1Last;
  logic [31:0] rsp0Data, rsp1Data;
  logic [1:0]  rsp0Resp, rsp1Resp;
  logic        protoErr;
  logic [0:0]  arId;
  logic [31:0] arAddr;
  logic [7:0]  arLen;
  logic [2:0]  arSize;
  logic [1:0]  arBurst;
  logic        arLock;
  logic [3:0]  arCache;
  logic [2:0]  arProt;
  logic [3:0]  arQos;
  logic [0:0]  arUser;
  logic        arValid, arReady;
  logic [0:0]  rId;
  logic [31:0] rData;
  logic [1:0]  rResp;
  logic        rLast, rValid, rReady;

  int errCount = 0;
  int checkCount = 0;

  axi_rd_arbiter dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rstN),
    .req0_valid(req0Valid), .req0_ready(req0Ready), .req0_addr(req0Addr), .req0_len(req0Len),
    .rsp0_valid(rsp0Valid), .rsp0_ready(rsp0Ready), .rsp0_data(rsp0Data), .rsp0_resp(rsp0Resp), .rsp0_last(rsp0Last),
    .req1_valid(req1Valid), .req1_ready(req1Ready), .req1_addr(req1Addr), .req1_len(req1Len),
    .rsp1_valid(rsp1Valid), .rsp1_ready(rsp1Ready), .rsp1_data(rsp1Data), .rsp1_resp(rsp1Resp), .rsp1_last(rsp1Last),
    .proto_err(protoErr),
    .m_axi_arid(arId), .m_axi_araddr(arAddr), .m_axi_arlen(arLen), .m_axi_arsize(arSize),
    .m_axi_arburst(arBurst), .m_axi_arlock(arLock), .m_axi_arcache(arCache), .m_axi_arprot(arProt),
    .m_axi_arqos(arQos), .m_axi_aruser(arUser), .m_axi_arvalid(arValid), .m_axi_arready(arReady),
    .m_axi_rid(rId), .m_axi_rdata(rData), .m_axi_rresp(rResp), .m_axi_rlast(rLast),
    .m_axi_rvalid(rValid), .m_axi_rready(rReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expFlags: {req0Ready, req1Ready, arValid, rReady, rsp0Valid, rsp1Valid, rsp0Last, rsp1Last, protoErr}
  typedef struct {
    logic        r0v;
    logic [31:0] r0a;
    logic [7:0]  r0l;
    logic        r1v;
    logic [31:0] r1a;
    logic [7:0]  r1l;
    logic        arRdy;
    logic        rVal;
    logic [31:0] rDat;
    logic        rLst;
    logic        s0Rdy;
    logic        s1Rdy;
    logic [8:0]  expFlags;
    logic [31:0] expAddr;
    logic [7:0]  expLen;
    logic        expId;
  } vecT;

  vecT vecs[$];
  logic tieWin[3];

  function automatic vecT mkVec(input logic r0v, input logic [31:0] r0a, input logic [7:0] r0l,
                                input logic r1v, input logic [31:0] r1a, input logic [7:0] r1l,
                                input logic arRdy, input logic rVal, input logic [31:0] rDat, input logic rLst,
                                input logic s0Rdy, input logic s1Rdy, input logic [8:0] expFlags,
                                input logic [31:0] expAddr, input logic [7:0] expLen, input logic expId);
    vecT v;
    v.r0v = r0v; v.r0a = r0a; v.r0l = r0l;
    v.r1v = r1v; v.r1a = r1a; v.r1l = r1l;
    v.arRdy = arRdy; v.rVal = rVal; v.rDat = rDat; v.rLst = rLst;
    v.s0Rdy = s0Rdy; v.s1Rdy = s1Rdy;
    v.expFlags = expFlags; v.expAddr = expAddr; v.expLen = expLen; v.expId = expId;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs;
    req0Valid = 1'b0; req0Addr = '0; req0Len = '0;
    req1Valid = 1'b0; req1Addr = '0; req1Len = '0;
    rsp0Ready = 1'b0; rsp1Ready = 1'b0;
    arReady = 1'b0; rValid = 1'b0; rData = '0; rResp = '0; rLast = 1'b0; rId = '0;
  endtask

  task automatic applyStimulus(input vecT v);
    req0Valid = v.r0v; req0Addr = v.r0a; req0Len = v.r0l;
    req1Valid = v.r1v; req1Addr = v.r1a; req1Len = v.r1l;
    arReady = v.arRdy; rValid = v.rVal; rData = v.rDat; rResp = v.rDat[1:0]; rLast = v.rLst;
    rsp0Ready = v.s0Rdy; rsp1Ready = v.s1Rdy;
  endtask

  task automatic checkOutput(input vecT v, input int idx);
    logic [8:0] actFlags;
    actFlags = {req0Ready, req1Ready, arValid, rReady, rsp0Valid, rsp1Valid, rsp0Last, rsp1Last, protoErr};
    checkVal($sformatf("vec%0d flags", idx), 64'(actFlags), 64'(v.expFlags));
    if (v.expFlags[6])
      checkVal($sformatf("vec%0d ar", idx), 64'({arId, arLen, arAddr}), 64'({v.expId, v.expLen, v.expAddr}));
    if (v.expFlags[4])
      checkVal($sformatf("vec%0d rsp0", idx), 64'({rsp0Resp, rsp0Data}), 64'({v.rDat[1:0], v.rDat}));
    if (v.expFlags[3])
      checkVal($sformatf("vec%0d rsp1", idx), 64'({rsp1Resp, rsp1Data}), 64'({v.rDat[1:0], v.rDat}));
  endtask

  task automatic runTie(input logic expWin, input int idx);
    clearInputs;
    req0Valid = 1'b1; req0Addr = 32'h100;
    req1Valid = 1'b1; req1Addr = 32'h200;
    #1;
    checkVal($sformatf("tie%0d ready", idx), 64'({req0Ready, req1Ready}), 64'(expWin ? 2'b01 : 2'b10));
    stepCycle;
    clearInputs; arReady = 1'b1; #1;
    checkVal($sformatf("tie%0d arid", idx), 64'({arValid, arId}), 64'({1'b1, expWin}));
    stepCycle;
    clearInputs; rValid = 1'b1; rLast = 1'b1; rsp0Ready = 1'b1; rsp1Ready = 1'b1; #1;
    checkVal($sformatf("tie%0d beat", idx), 64'({rReady, rsp0Valid, rsp1Valid}), 64'({1'b1, ~expWin, expWin}));
    stepCycle;
    clearInputs;
  endtask

  initial begin
`ifdef AXI_RD_ARB_RR_EN
    tieWin[0] = 1'b0; tieWin[1] = 1'b1; tieWin[2] = 1'b0;
`else
    tieWin[0] = 1'b1; tieWin[1] = 1'b1; tieWin[2] = 1'b1;
`endif
    // single 4-beat burst on port 0
    vecs.push_back(mkVec(1, 32'h1000, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b100000000, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 9'b001000000, 32'h1000, 3, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'hA0, 0, 1, 0, 9'b000110000, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'hA1, 0, 1, 0, 9'b000110000, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'hA2, 0, 1, 0, 9'b000110000, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'hA3, 1, 1, 0, 9'b000110100, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b000000000, 0, 0, 0));
    // simultaneous requests, port 0 holds valid while port 1 is served
    vecs.push_back(mkVec(1, 32'h100, 0, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 9'b010000000, 0, 0, 0));
    vecs.push_back(mkVec(1, 32'h100, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 9'b001000000, 32'h200, 0, 1));
    vecs.push_back(mkVec(1, 32'h100, 0, 0, 0, 0, 0, 1, 32'hB0, 1, 0, 1, 9'b000101010, 0, 0, 0));
    vecs.push_back(mkVec(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b100000000, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 9'b001000000, 32'h100, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'hB1, 1, 1, 0, 9'b000110100, 0, 0, 0));
    // AR backpressure then R backpressure on port 1
    vecs.push_back(mkVec(0, 0, 0, 1, 32'h2000, 2, 0, 0, 0, 0, 0, 0, 9'b010000000, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mkVec(0, 0, 0, 0, 32'hDEAD, 7, 0, 0, 0, 0, 0, 0, 9'b001000000, 32'h2000, 2, 1));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 9'b001000000, 32'h2000, 2, 1));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'hC0, 0, 0, 1, 9'b000101000, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'hC1, 0, 0, 0, 9'b000001000, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'hC1, 0, 0, 1, 9'b000101000, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'hC2, 1, 0, 1, 9'b000101010, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b000000000, 0, 0, 0));
    // early rlast on a 2-beat burst; counter still ends it
    vecs.push_back(mkVec(1, 32'h4000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b100000000, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 9'b001000000, 32'h4000, 1, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'hD0, 1, 1, 0, 9'b000110000, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'hD1, 1, 1, 0, 9'b000110101, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b000000001, 0, 0, 0));

    clearInputs;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset flags", 64'({req0Ready, req1Ready, arValid, rReady, rsp0Valid, rsp1Valid, protoErr}), 64'(0));
    checkVal("ar consts", 64'({arSize, arBurst, arCache, arLock, arProt, arQos, arUser}),
             64'({3'd2, 2'b01, 4'b0011, 1'b0, 3'b000, 4'b0000, 1'b0}));
    rstN = 1'b1;
    stepCycle;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
      stepCycle;
    end

    // over-length request saturates to 16 beats
    clearInputs; req1Valid = 1'b1; req1Addr = 32'h6000; req1Len = 8'd40; #1;
    checkVal("ovl ready", 64'({req0Ready, req1Ready}), 64'(2'b01));
    stepCycle;
    clearInputs; arReady = 1'b1; #1;
    checkVal("ovl ar", 64'({arValid, arLen, arAddr}), 64'({1'b1, 8'd15, 32'h6000}));
    stepCycle;
    for (int i = 0; i < 16; i++) begin
      clearInputs; rValid = 1'b1; rData = 32'hF000 + 32'(i); rLast = (i == 15); rsp1Ready = 1'b1; #1;
      checkVal($sformatf("ovl beat%0d", i), 64'({rsp1Valid, rsp1Last, rsp1Data}),
               64'({1'b1, (i == 15), 32'hF000 + 32'(i)}));
      stepCycle;
    end
    clearInputs; #1;
    checkVal("ovl idle", 64'({arValid, rReady, protoErr}), 64'(3'b001));

    for (int i = 0; i < 3; i++) runTie(tieWin[i], i);

    // reset in the middle of a 4-beat burst
    clearInputs; req0Valid = 1'b1; req0Addr = 32'h5000; req0Len = 8'd3; #1;
    checkVal("rst req", 64'(req0Ready), 64'(1));
    stepCycle;
    clearInputs; arReady = 1'b1; stepCycle;
    for (int i = 0; i < 2; i++) begin
      clearInputs; rValid = 1'b1; rData = 32'hE0 + 32'(i); rsp0Ready = 1'b1; stepCycle;
    end
    clearInputs; rValid = 1'b1; rsp0Ready = 1'b1; #1;
    checkVal("rst pre", 64'({rReady, rsp0Valid, rsp0Last, protoErr}), 64'(4'b1101));
    rstN = 1'b0; #1;
    checkVal("rst async", 64'({arValid, rReady, rsp0Valid, rsp1Valid, protoErr}), 64'(0));
    stepCycle;
    clearInputs; rstN = 1'b1;
    stepCycle;
    req0Valid = 1'b1; req0Addr = 32'h7000; #1;
    checkVal("post rst req", 64'({req0Ready, req1Ready}), 64'(2'b10));
    stepCycle;
    clearInputs; arReady = 1'b1; #1;
    checkVal("post rst ar", 64'({arValid, arId, arLen, arAddr}), 64'({1'b1, 1'b0, 8'd0, 32'h7000}));
    stepCycle;
    clearInputs; rValid = 1'b1; rLast = 1'b1; rsp0Ready = 1'b1; #1;
    checkVal("post rst beat", 64'({rsp0Valid, rsp0Last, protoErr}), 64'(3'b110));
    stepCycle;
    clearInputs;

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-requester read arbiter and sequencer for the core's single AXI4 master read channel. Instruction fetch (port 0) and data load (port 1) each issue burst read requests over a simple valid/ready interface. The block grants one requester, drives the AR channel, and steers R beats back to the granted requester until the burst completes. It sits between the fetch/LSU units and the AXI master interface's master modport; the write channels are outside its scope.

## Interface
Parameters:
- C_M_AXI_BURST_LEN, 16: maximum beats per burst.
- C_M_AXI_ADDR_WIDTH, 32: address width.
- C_M_AXI_DATA_WIDTH, 32: data width.
- C_M_AXI_ID_WIDTH, 1: ID width, at least 1.

Ports (N = 0, 1):
- m_axi_aclk  in  1  clock. The block has one clock; reset is asynchronous and active-low.
- m_axi_aresetn  in  1  asynchronous active-low reset.
- reqN_valid  in  1  request valid.
- reqN_ready  out  1  request accepted.
- reqN_addr  in  ADDR_WIDTH  burst start address.
- reqN_len  in  8  beats minus 1.
- rspN_valid  out  1  response beat valid.
- rspN_ready  in  1  requester accepts the beat.
- rspN_data  out  DATA_WIDTH  beat data.
- rspN_resp  out  2  RRESP of the beat.
- rspN_last  out  1  final beat of the burst, derived from the beat counter.
- proto_err  out  1  sticky; set when m_axi_rlast disagrees with the beat counter.
- m_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,user,valid}  out  per AXI4  read address channel.
- m_axi_arready  in  1.
- m_axi_r{id,data,resp,last,valid}  in  per AXI4  read data channel.
- m_axi_rready  out  1.

## Operation
- FSM states: IDLE, ADDR, DATA. Reset enters IDLE.
- IDLE:
  - If any reqN_valid is high, select a winner, pulse the winner's reqN_ready for that cycle, and register addr, len and grant. Next state is ADDR.
  - Fixed priority: port 1 (data) beats port 0.
- ADDR:
  - m_axi_arvalid = 1, with registered fields held stable until m_axi_arready.
  - On arready, clear the beat counter. Next state is DATA.
- DATA:
  - The granted port sees rspN_valid = m_axi_rvalid and m_axi_rready = rspN_ready (combinational pass-through of data and resp).
  - The ungranted port's rsp_valid is 0.
  - Each beat handshake increments the counter. rsp_last = (counter == len).
  - On the handshake with counter == len, return to IDLE.
- Length: reqN_len above BURST_LEN−1 saturates to BURST_LEN−1.
- Constant AR fields:
  - arsize = log2(DATA_WIDTH/8), arburst = 2'b01 (INCR), arcache = 4'b0011.
  - arlock, arprot, arqos, aruser = 0.
  - arid = grant index, zero-extended.
- Protocol check: on any beat handshake where m_axi_rlast != rsp_last, set proto_err. It is cleared only by reset. The burst end is always governed by the counter.

## Timing
- Reset values: reqN_ready 0, rspN_valid 0, m_axi_arvalid 0, m_axi_rready 0, proto_err 0, counter 0, grant 0, round-robin pointer 0.
- Earliest m_axi_arvalid is 1 cycle after the accepting reqN_valid cycle.
- R beats carry zero added latency.
- The next grant happens no earlier than the cycle after the last beat, so consecutive bursts have at least 1 idle IDLE cycle.
- Simultaneous requests in IDLE: exactly one reqN_ready is asserted; the loser holds valid and waits.
- Requests are never accepted in ADDR or DATA.
- Reset asserted mid-burst: return asynchronously to IDLE and drop arvalid/rready. The outstanding AXI transaction is abandoned; the system resets the slave together with this block.

## Configuration
- AXI_RD_ARB_RR_EN:
  - Defined: round-robin arbitration. A 1-bit pointer toggles to favour the other port after each grant; on a tie the pointer's port wins.
  - Undefined: fixed priority, port 1 over port 0; no pointer register.

## Structure
- axi_rd_arb_pkg holds:
  - the state enum (IDLE, ADDR, DATA);
  - constants AXI_BURST_INCR = 2'b01 and AXI_CACHE_DEFAULT = 4'b0011;
  - the function computing arsize from data width.
- One sub-module, axi_rd_arb_grant: the combinational winner selection plus the round-robin pointer register, controlled by AXI_RD_ARB_RR_EN.

## Test plan
- Single request: req0 addr 0x1000, len 3, arready same cycle, 4 R beats with rlast on the 4th. Expect arvalid at cycle+1 with araddr 0x1000, arlen 3, arid 0; rsp0 sees 4 beats with rsp0_last on beat 4; return to IDLE.
- Simultaneous requests (0x100/len 0 and 0x200/len 0):
  - Fixed priority: port 1 is granted first and port 0 follows after 1 idle cycle.
  - With RR_EN, repeated ties alternate grants.
- Backpressure: arready held low 5 cycles, then rsp1_ready toggles 1,0,1 during a len 2 burst. Expect the AR fields to stay stable and every beat to be delivered once, in order.
- Over-length: reqN_len 40 with BURST_LEN 16 drives arlen 15.
- Protocol error: len 1 burst with rlast on beat 1. Expect proto_err=1, and the burst still ends after beat 2.
- Reset mid-DATA after 2 of 4 beats: arvalid, rready and rsp_valid read 0 immediately; a new req0 is accepted after reset release.
